// File: rtl/bram_ns_operand_fifo_if.sv
// Operand FIFO bus: write stream, issue demand and operand outputs.
// The slave modport is the FIFO, the master modport is its user.
interface bram_ns_operand_fifo_if #(
  parameter int dataWidth = 16,
  parameter int depthLog  = 4
);
  logic                 flush;
  logic                 wr_v;
  logic [dataWidth-1:0] wr_data;
  logic                 wr_ready;
  logic                 inst_valid;
  logic                 src0_rq;
  logic                 src1_rq;
  logic                 inst_stall;
  logic                 out_v;
  logic [dataWidth-1:0] src0_data;
  logic [dataWidth-1:0] src1_data;
  logic [depthLog:0]    count;
  logic                 underflow_err;

  modport slave (
    input  flush,
    input  wr_v,
    input  wr_data,
    output wr_ready,
    input  inst_valid,
    input  src0_rq,
    input  src1_rq,
    input  inst_stall,
    output out_v,
    output src0_data,
    output src1_data,
    output count,
    output underflow_err
  );

  modport master (
    output flush,
    output wr_v,
    output wr_data,
    input  wr_ready,
    output inst_valid,
    output src0_rq,
    output src1_rq,
    output inst_stall,
    input  out_v,
    input  src0_data,
    input  src1_data,
    input  count,
    input  underflow_err
  );
endinterface

// File: rtl/bram_ns_operand_fifo.sv
// Per-namespace operand FIFO: streamed writes, 0/1/2 pops per cycle.
// Head feeds src0; src1 takes the next entry when src0 also requests.
module bram_ns_operand_fifo #(
  parameter int dataWidth = 16,
  parameter int depthLog  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  bram_ns_operand_fifo_if.slave bus
);

  localparam int Depth = 1 << depthLog;
  localparam logic [depthLog:0] DepthC = (depthLog+1)'(Depth);

  logic [dataWidth-1:0] mem [Depth];
  logic [depthLog-1:0]  rd_ptr;
  logic [depthLog-1:0]  wr_ptr;
  logic [depthLog:0]    count;
  logic                 underflow_err;

  logic [1:0]           need;
  logic [depthLog:0]    need_w;
  logic [depthLog-1:0]  rd_nxt;
  logic                 consume;
  logic                 can_pop;
  logic                 pop;
  logic                 accept;
  logic                 wr_ready;
  logic [depthLog:0]    pop_amt;
  logic [depthLog:0]    acc_amt;
  logic [depthLog-1:0]  rd_step;

  // Demand decode and pop/accept qualification.
  always_comb begin
    need    = {1'b0, bus.src0_rq} + {1'b0, bus.src1_rq};
    need_w  = (depthLog+1)'(need);
    consume = bus.inst_valid && !bus.inst_stall
              && (need != 2'd0);
    can_pop = (count >= need_w);
    pop     = consume && can_pop;
    // No pass-through when full: a same-cycle pop does not free a slot.
    wr_ready = (count != DepthC);
    accept  = bus.wr_v && wr_ready;
    pop_amt = pop ? need_w : '0;
    acc_amt = (depthLog+1)'(accept);
    rd_step = pop ? need_w[depthLog-1:0] : '0;
    rd_nxt  = rd_ptr + depthLog'(1);
  end

  // Pointer, occupancy and sticky error state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      underflow_err <= 1'b0;
    end else if (bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + depthLog'(1);
      end
      rd_ptr <= rd_ptr + rd_step;
      count  <= count + acc_amt - pop_amt;
      // Consuming without enough operands means the stall logic slipped.
      if (consume && !can_pop) begin
        underflow_err <= 1'b1;
      end
    end
  end

  // Storage array; cleared on reset, untouched by flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
    end else if (accept && !bus.flush) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  assign bus.wr_ready      = wr_ready;
  assign bus.out_v         = (need == 2'd0) ? (count != '0)
                                            : can_pop;
  assign bus.src0_data     = mem[rd_ptr];
  assign bus.src1_data     = bus.src0_rq ? mem[rd_nxt]
                                         : mem[rd_ptr];
  assign bus.count         = count;
  assign bus.underflow_err = underflow_err;

endmodule

// File: tb/tb_bram_ns_operand_fifo.sv
// Directed bench for bram_ns_operand_fifo.
// Vector table for the basic flow, hand sequences for corners.
module tb_bram_ns_operand_fifo;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  bram_ns_operand_fifo_if #(.dataWidth(16), .depthLog(4)) bus ();

  bram_ns_operand_fifo #(.dataWidth(16), .depthLog(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        wv;
    logic [15:0] wd;
    logic        iv;
    logic        s0;
    logic        s1;
    logic        st;
    logic        e_ov;
    logic        e_wr;
    logic [15:0] e_s0;
    logic [15:0] e_s1;
    logic [4:0]  e_cnt;
    logic        e_err;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [15:0] wd,
                       input logic iv, input logic s0,
                       input logic s1, input logic st,
                       input logic fl);
    bus.wr_v       = wv;
    bus.wr_data    = wd;
    bus.inst_valid = iv;
    bus.src0_rq    = s0;
    bus.src1_rq    = s1;
    bus.inst_stall = st;
    bus.flush      = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset_n = 1'b0;
    idle();

    //       wv  wd      iv  s0  s1  st  ov  wr  s0d      s1d      cnt  err
    tbl[0] = {1'b1, 16'h0011, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b0, 1'b1, 16'h0000, 16'h0000, 5'd0, 1'b0};
    tbl[1] = {1'b1, 16'h0022, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b1, 1'b1, 16'h0011, 16'h0011, 5'd1, 1'b0};
    tbl[2] = {1'b1, 16'h0033, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b1, 1'b1, 16'h0011, 16'h0011, 5'd2, 1'b0};
    tbl[3] = {1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0,
              1'b1, 1'b1, 16'h0011, 16'h0022, 5'd3, 1'b0};
    tbl[4] = {1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1,
              1'b0, 1'b1, 16'h0033, 16'h0000, 5'd1, 1'b0};
    tbl[5] = {1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0,
              1'b0, 1'b1, 16'h0033, 16'h0000, 5'd1, 1'b0};
    tbl[6] = {1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b1, 1'b1, 16'h0033, 16'h0033, 5'd1, 1'b1};

    #2;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_out_v", 32'(bus.out_v), 32'd0);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("rst_src0", 32'(bus.src0_data), 32'd0);
    chk("rst_src1", 32'(bus.src1_data), 32'd0);
    chk("rst_err", 32'(bus.underflow_err), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].wv, tbl[i].wd, tbl[i].iv, tbl[i].s0,
            tbl[i].s1, tbl[i].st, 1'b0);
      #1;
      chk($sformatf("v%0d_out_v", i), 32'(bus.out_v),
          32'(tbl[i].e_ov));
      chk($sformatf("v%0d_wr_ready", i), 32'(bus.wr_ready),
          32'(tbl[i].e_wr));
      chk($sformatf("v%0d_src0", i), 32'(bus.src0_data),
          32'(tbl[i].e_s0));
      chk($sformatf("v%0d_src1", i), 32'(bus.src1_data),
          32'(tbl[i].e_s1));
      chk($sformatf("v%0d_count", i), 32'(bus.count),
          32'(tbl[i].e_cnt));
      chk($sformatf("v%0d_err", i), 32'(bus.underflow_err),
          32'(tbl[i].e_err));
      tick();
    end

    // Full: no accept even with a same-cycle pop.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 16'(16'h00A0 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    idle();
    #1;
    chk("full_count", 32'(bus.count), 32'd16);
    chk("full_wr_ready", 32'(bus.wr_ready), 32'd0);
    drive(1'b1, 16'h00EE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("full_wr_ready_pop", 32'(bus.wr_ready), 32'd0);
    chk("full_src1_head", 32'(bus.src1_data), 32'h00A0);
    chk("full_out_v", 32'(bus.out_v), 32'd1);
    tick();
    idle();
    #1;
    chk("full_pop_count", 32'(bus.count), 32'd15);
    chk("full_pop_head", 32'(bus.src0_data), 32'h00A1);

    // Wrap-around of the read pointer on a double pop.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 14; i++) begin
      drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    for (int i = 15; i < 19; i++) begin
      drive(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("wrap_count", 32'(bus.count), 32'd5);
    chk("wrap_src0_a", 32'(bus.src0_data), 32'h010E);
    chk("wrap_src1_a", 32'(bus.src1_data), 32'h010F);
    tick();
    #1;
    chk("wrap_src0_b", 32'(bus.src0_data), 32'h0110);
    chk("wrap_src1_b", 32'(bus.src1_data), 32'h0111);
    tick();
    idle();
    #1;
    chk("wrap_rd_ptr2", 32'(bus.src0_data), 32'h0112);
    chk("wrap_count_end", 32'(bus.count), 32'd1);

    // Flush with a concurrent write.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    idle();
    #1;
    chk("pre_flush_count", 32'(bus.count), 32'd5);
    drive(1'b1, 16'h0BAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    #1;
    chk("flush_count", 32'(bus.count), 32'd0);
    chk("flush_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("flush_out_v", 32'(bus.out_v), 32'd0);
    chk("flush_mem_kept", 32'(bus.src0_data), 32'h0110);

    // Underflow on an empty FIFO, then reset mid-write clears it.
    drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    chk("empty_underflow", 32'(bus.underflow_err), 32'd1);
    chk("empty_underflow_cnt", 32'(bus.count), 32'd0);
    drive(1'b1, 16'h0301, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0302, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_count", 32'(bus.count), 32'd0);
    chk("midrst_out_v", 32'(bus.out_v), 32'd0);
    chk("midrst_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("midrst_src0", 32'(bus.src0_data), 32'd0);
    chk("midrst_src1", 32'(bus.src1_data), 32'd0);
    chk("midrst_err", 32'(bus.underflow_err), 32'd0);
    tick();
    idle();
    reset_n = 1'b1;
    tick();
    #1;
    chk("post_rst_count", 32'(bus.count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bram_ns_operand_fifo.md
Name: bram_ns_operand_fifo

Overview:
- Producer-side operand buffer for one BRAM namespace (data, weight or meta), one instance per namespace in each PE.
- Accepts operand words streamed from the memory interface.
- Drives the namespace's `*_out_v` flag and the operand words seen by the PE's BRAM stall logic and ALU source muxes.
- Pops 0, 1 or 2 entries per cycle, as the issuing instruction consumes them on src0 and/or src1.

Parameters:
- dataWidth, 16, operand word width in bits.
- depthLog, 4, log2 of FIFO depth (depth = 16).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all entries.
- wr_v  input  1  write-side word valid.
- wr_data  input  dataWidth  write-side word.
- wr_ready  output  1  FIFO can accept a word this cycle.
- inst_valid  input  1  the current instruction is valid.
- src0_rq  input  1  src0 decoder selects this namespace.
- src1_rq  input  1  src1 decoder selects this namespace.
- inst_stall  input  1  global instruction stall (OR of all stall sources, including the BRAM stall).
- out_v  output  1  operands available for the current demand; feeds `*_out_v`.
- src0_data  output  dataWidth  operand word for src0.
- src1_data  output  dataWidth  operand word for src1.
- count  output  depthLog+1  number of occupied entries.
- underflow_err  output  1  sticky error flag.

Behaviour:
- Storage and reset:
  - State is: mem[depth], rd_ptr, wr_ptr (depthLog bits, wrap mod depth), count (depthLog+1 bits).
  - reset_n low clears immediately: rd_ptr=0, wr_ptr=0, count=0, underflow_err=0, all mem words=0.
  - Outputs after reset: wr_ready=1, out_v=0, src0_data=0, src1_data=0, count=0.
- Demand:
  - need = src0_rq + src1_rq (0..2).
  - out_v = (need==0) ? (count!=0) : (count>=need). Purely combinational from count, src0_rq and src1_rq.
- Operand mapping (combinational reads):
  - src0_data = mem[rd_ptr].
  - src1_data = src0_rq ? mem[rd_ptr+1] : mem[rd_ptr], with index mod depth.
  - When both sources request, src0 takes the head entry and src1 takes the next entry.
- Write:
  - wr_ready = (count != depth). It is independent of a same-cycle pop; there is no full-throughput pass-through.
  - Accept when wr_v && wr_ready: mem[wr_ptr] <= wr_data, and wr_ptr increments.
  - A written word is visible on src*_data and counted in out_v from the next cycle. There is no write-to-read bypass.
- Consume:
  - consume = inst_valid && !inst_stall && (need!=0).
  - If consume && count>=need: rd_ptr += need.
  - If consume && count<need: no pop, pointers unchanged, underflow_err <= 1. This is sticky until reset and indicates a stall-logic bug.
- Count update per cycle: count_next = count + accept − pop, where pop is need or 0. Simultaneous write and pop are both applied in the same cycle.
- Full and wrap-around:
  - At count==depth, wr_ready=0 even if a pop occurs in the same cycle.
  - A double pop with rd_ptr==depth−1 reads mem[depth−1] and mem[0], and rd_ptr becomes 1.
- Flush:
  - flush high sets rd_ptr=0, wr_ptr=0 and count=0 at the next edge.
  - Writes and pops in the same cycle are discarded.
  - mem contents and underflow_err are unchanged.
- Reset mid-stream: asserting reset_n low at any time returns all state to reset values. In-flight writes are dropped.

Test Plan:
- Reset then write 0x11, 0x22, 0x33 on consecutive cycles with no requests:
  - count reaches 3.
  - out_v=0 during the write of 0x11.
  - out_v=1 from the cycle after.
- With count=3 [0x11, 0x22, 0x33], set src0_rq=src1_rq=1, inst_valid=1, inst_stall=0 for one cycle:
  - src0_data=0x11, src1_data=0x22.
  - Next cycle: count=1, src0_data=0x33.
- With count=1, set src0_rq=src1_rq=1:
  - out_v=0.
  - With inst_stall=1: no pop and underflow_err stays 0.
  - Force inst_stall=0: no pop, count stays 1, underflow_err=1.
- Fill to 16 entries:
  - wr_ready=0.
  - A write with a same-cycle single pop (src1_rq only) is not accepted: count becomes 15, and src1_data equals the head before the pop.
- Wrap-around:
  - Write 15, pop 14, then write 4, so rd_ptr=14.
  - A double pop returns mem[14] and mem[15].
  - A further double pop returns mem[0] and mem[1], and rd_ptr becomes 2.
- Assert flush with count=5 and a concurrent write:
  - Next cycle: count=0, wr_ready=1, out_v=0 (need=0).
- Assert reset_n low mid-write:
  - All outputs return to reset values immediately.
